mac_result_drain: RTL and testbench
===================================

// Module: mac_result_drain
// PURPOSE
//  Read-side consumer of the 2x2 MAC array results. Captures acc_out_0..3 on each lane's valid_out pulse.
//  Serialises the captured results onto one ready/valid stream in fixed lane order 0,1,2,3,0,...
//  Flags the last beat of each tile. Sits between mac_array and the output buffer/writeback path.
// PARAMETERS
//  ACC_W   16  accumulator/result width (signed), matches mac_array ACC_W
//  N_MACS   4  number of result lanes; lane index width LW = $clog2(N_MACS)
// PORTS
//  clk         in   1             clock; all logic on rising edge
//  rst         in   1             synchronous, active-high reset
//  flush       in   1             soft clear of pending results and lane pointer
//  acc_in_0    in   ACC_W         MAC 0 result (signed)
//  acc_in_1    in   ACC_W         MAC 1 result (signed)
//  acc_in_2    in   ACC_W         MAC 2 result (signed)
//  acc_in_3    in   ACC_W         MAC 3 result (signed)
//  valid_in    in   N_MACS        per-lane result-valid pulse (from mac_array valid_out)
//  out_data    out  ACC_W         serialised result (signed)
//  out_lane    out  LW            source lane of out_data
//  out_last    out  1             beat carries lane N_MACS-1 (end of tile)
//  out_valid   out  1             stream valid
//  out_ready   in   1             stream ready from downstream
//  overrun     out  1             sticky: a result arrived on a lane whose capture slot was still full
//  busy        out  1             any lane pending or out_valid high
// BEHAVIOUR
//  - Reset (rst=1): pending[]=0, head=0, out_valid=0, out_data=0, out_lane=0, out_last=0, overrun=0, busy=0.
//  - Capture: valid_in[i]=1 with pending[i]=0 -> slot[i]<=acc_in_i, pending[i]<=1 next cycle.
//  - Overrun: valid_in[i]=1 with pending[i]=1 and slot i not being drained this cycle.
//      -> new value dropped, slot keeps the old value, overrun<=1.
//      -> overrun clears only on rst or flush.
//  - Same-cycle drain+capture on lane i: the slot is freed and the new value is captured. No overrun.
//  - Emission order is strict: only lane `head` may load the output register. Other pending lanes wait.
//  - Output register load: when (!out_valid || out_ready) && pending[head]:
//      out_data<=slot[head], out_lane<=head, out_last<=(head==N_MACS-1), out_valid<=1.
//      pending[head]<=0; head<=head+1, wrapping N_MACS-1 -> 0.
//  - When (!out_valid || out_ready) && !pending[head]: out_valid<=0.
//  - Latency: valid_in[i] at cycle t -> earliest out_valid at t+2 (capture t+1, output reg t+2).
//  - Throughput: one beat per cycle when lanes are pending in order and out_ready=1.
//  - Stream hold: while out_valid && !out_ready, out_data/out_lane/out_last are held stable.
//  - Handshake: a beat transfers on out_valid && out_ready. out_valid never drops without a transfer (except rst/flush).
//  - flush=1: same clearing as rst, but only on the cycle it is asserted. flush wins over same-cycle valid_in (inputs dropped).
//  - busy = |pending || out_valid (combinational).
//  - No arithmetic on data except the optional feature. Widths pass through unchanged, sign preserved.
// CONFIGURATION
//  MAC_DRAIN_RELU_EN defined:
//    a result with sign bit set is replaced by 0 when loaded into the output register.
//    Capture slots still hold the raw value.
//  MAC_DRAIN_RELU_EN undefined: out_data is the raw captured value.
// STRUCTURE
//  Shared package mac_pkg holds:
//    ACC_W / N_MACS defaults, the LW lane-index localparam, and the signed acc_t result typedef.
//  One sub-module, mac_drain_lane: a single-lane capture slot.
//    Inputs: capture, drain. Outputs: slot value, pending, overrun pulse.
//    Instantiated N_MACS times.
//  Top level owns the head pointer, output register, sticky overrun and the RELU option.
// TESTING
//  1. Tile in order: valid_in=4'b1111 with 10,-3,7,100; out_ready=1.
//     -> beats lane0..3 = 10,-3,7,100 on consecutive cycles; out_last only on 100; busy low after.
//  2. Out of order: valid_in[2] (5) at t, valid_in[0] (9) at t+3, then lanes 1 (4) and 3 (6).
//     -> emission order 9,4,5,6; nothing emitted before lane 0 arrives.
//  3. Backpressure: out_ready=0 for 5 cycles with a full tile pending.
//     -> out_data=lane0 held stable, out_valid=1; after release, all 4 beats drain with no loss.
//  4. Overrun: lane1 captured -1234 and stalled behind an empty lane 0; second valid_in[1] with 55.
//     -> overrun=1 sticky; lane1 later emits -1234.
//  5. Flush/reset mid-tile: 2 lanes pending and out_valid=1, then flush for 1 cycle.
//     -> out_valid=0, busy=0, overrun=0, head=0; the next tile starts at lane 0. Repeat with rst.
//  6. RELU build: lane values -8,0,16,-32768 -> out 0,0,16,0; without macro -> raw values.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC array result path: result width, lane
// count, lane-index width and the signed result type, plus small helpers
// used by the drain logic.
package mac_pkg;

   localparam int ACC_W  = 16;
   localparam int N_MACS = 4;
   localparam int LW     = $clog2(N_MACS);

   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic [LW-1:0]           lane_t;

   localparam lane_t LAST_LANE = lane_t'(N_MACS - 1);

   // Advance the round-robin lane pointer, wrapping after the last lane.
   function automatic lane_t next_lane(input lane_t lane);
      return (lane == LAST_LANE) ? '0 : lane + lane_t'(1);
   endfunction

   // Clamp negative results to zero; used only by the rectifying build.
   function automatic acc_t relu(input acc_t value);
      return value[ACC_W-1] ? '0 : value;
   endfunction

endpackage

// File: rtl/mac_result_drain_if.sv
// Serialised result stream leaving the drain. The master side (the drain)
// drives data/lane/last/valid; the slave side (output buffer) drives ready.
//
// Handshake: a beat transfers on a rising edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_data, out_lane and
// out_last stay stable and out_valid stays high until that transfer happens
// (only reset or flush can withdraw a beat). out_ready may change freely and
// has no combinational path back to out_valid.
interface mac_result_drain_if;
   import mac_pkg::*;

   acc_t  out_data;
   lane_t out_lane;
   logic  out_last;
   logic  out_valid;
   logic  out_ready;

   modport master (
      output out_data,
      output out_lane,
      output out_last,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_lane,
      input  out_last,
      input  out_valid,
      output out_ready
   );

endinterface

// File: rtl/mac_drain_lane.sv
// Single-lane capture slot. Holds one result until the output register
// takes it. A capture arriving while the slot is still full is dropped and
// reported as a one-cycle overrun pulse, unless the slot is being drained on
// that same edge, in which case the new value simply replaces the old one.
module mac_drain_lane
   import mac_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic capture,
   input  logic drain,
   input  acc_t acc_in,
   output acc_t slot,
   output logic pending,
   output logic overrun_pulse
);

   logic accept;

   // The slot can take a new value when it is empty or emptying this cycle.
   assign accept = capture && (!pending || drain);

   // Dropped capture: slot full and not being emptied. Flush discards inputs,
   // so a capture during flush is not an overrun.
   assign overrun_pulse = capture && pending && !drain && !flush;

   // Slot storage and pending flag; flush behaves like reset for one cycle.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         slot    <= '0;
         pending <= 1'b0;
      end else if (accept) begin
         slot    <= acc_in;
         pending <= 1'b1;
      end else if (drain) begin
         pending <= 1'b0;
      end
   end

endmodule

// File: rtl/mac_result_drain.sv
// Read-side consumer of the 2x2 MAC array. Each lane's result is captured
// on its valid pulse into a private slot, then the slots are emitted one at
// a time on a single ready/valid stream in strict lane order 0,1,2,3,0,...
// out_last marks the beat from the final lane of a tile.
//
// Optional build macro MAC_DRAIN_RELU_EN: negative results are replaced by
// zero as they enter the output register (slots keep the raw value).
module mac_result_drain
   import mac_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  acc_t                 acc_in_0,
   input  acc_t                 acc_in_1,
   input  acc_t                 acc_in_2,
   input  acc_t                 acc_in_3,
   input  logic [N_MACS-1:0]    valid_in,
   mac_result_drain_if.master   out_if,
   output logic                 overrun,
   output logic                 busy
);

   acc_t                acc_in [N_MACS];
   acc_t                slot   [N_MACS];
   logic [N_MACS-1:0]   pending;
   logic [N_MACS-1:0]   drain;
   logic [N_MACS-1:0]   overrun_pulse;
   lane_t               head;
   logic                out_free;
   logic                load;
   acc_t                head_value;
   acc_t                load_value;

   assign acc_in[0] = acc_in_0;
   assign acc_in[1] = acc_in_1;
   assign acc_in[2] = acc_in_2;
   assign acc_in[3] = acc_in_3;

   // The output register may take a new beat when empty or transferring now.
   assign out_free = !out_if.out_valid || out_if.out_ready;

   // Only the head lane may be loaded; other pending lanes wait their turn.
   assign load = out_free && pending[head];

   assign head_value = slot[head];

`ifdef MAC_DRAIN_RELU_EN
   assign load_value = relu(head_value);
`else
   assign load_value = head_value;
`endif

   for (genvar i = 0; i < N_MACS; i++) begin : g_lane
      assign drain[i] = load && (head == lane_t'(i));

      mac_drain_lane u_lane (
         .clk           (clk),
         .rst           (rst),
         .flush         (flush),
         .capture       (valid_in[i]),
         .drain         (drain[i]),
         .acc_in        (acc_in[i]),
         .slot          (slot[i]),
         .pending       (pending[i]),
         .overrun_pulse (overrun_pulse[i])
      );
   end

   // Head pointer steps to the next lane each time the head slot is emitted.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head <= '0;
      end else if (load) begin
         head <= next_lane(head);
      end
   end

   // Output register: load the head slot when free, otherwise hold; go idle
   // only when the register is free and the head lane has nothing to send.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         out_if.out_data  <= '0;
         out_if.out_lane  <= '0;
         out_if.out_last  <= 1'b0;
         out_if.out_valid <= 1'b0;
      end else if (load) begin
         out_if.out_data  <= load_value;
         out_if.out_lane  <= head;
         out_if.out_last  <= (head == LAST_LANE);
         out_if.out_valid <= 1'b1;
      end else if (out_free) begin
         out_if.out_valid <= 1'b0;
      end
   end

   // Sticky overrun flag, cleared only by reset or flush.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         overrun <= 1'b0;
      end else if (|overrun_pulse) begin
         overrun <= 1'b1;
      end
   end

   assign busy = (|pending) || out_if.out_valid;

endmodule

// File: tb/tb_mac_result_drain.sv
// Self-checking bench for mac_result_drain: reset values, a table of tiles
// with staggered lane arrival and random backpressure, and hand-written
// sequences for latency, ordering, stall, overrun, same-cycle drain+capture,
// flush and reset.
module tb_mac_result_drain;
   import mac_pkg::*;

   localparam int EW = 1 + LW + ACC_W;   // {last, lane, data}

   typedef struct packed {
      logic [3:0][ACC_W-1:0] val;        // lane inputs
      logic [3:0][1:0]       dly;        // arrival cycle of each lane
      logic [3:0][ACC_W-1:0] exp;        // expected output data per lane
   } vec_t;

   logic              clk;
   logic              rst;
   logic              flush;
   acc_t              acc_in_0, acc_in_1, acc_in_2, acc_in_3;
   logic [N_MACS-1:0] valid_in;
   logic              overrun;
   logic              busy;

   mac_result_drain_if s_if ();

   mac_result_drain dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .acc_in_0 (acc_in_0),
      .acc_in_1 (acc_in_1),
      .acc_in_2 (acc_in_2),
      .acc_in_3 (acc_in_3),
      .valid_in (valid_in),
      .out_if   (s_if.master),
      .overrun  (overrun),
      .busy     (busy)
   );

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [EW-1:0] exp_q[$];
   logic          rand_ready = 1'b0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- model helpers ----------------
   function automatic acc_t mdl(input acc_t v);
`ifdef MAC_DRAIN_RELU_EN
      return (v < 0) ? acc_t'(0) : v;
`else
      return v;
`endif
   endfunction

   function automatic logic [EW-1:0] beat(input int lane, input acc_t raw);
      return {lane == N_MACS - 1, lane_t'(lane), mdl(raw)};
   endfunction

   function automatic vec_t mk(input int v0, input int v1, input int v2, input int v3,
                               input int d0, input int d1, input int d2, input int d3);
      vec_t r;
      r.val[0] = ACC_W'(v0); r.val[1] = ACC_W'(v1);
      r.val[2] = ACC_W'(v2); r.val[3] = ACC_W'(v3);
      r.dly[0] = 2'(d0); r.dly[1] = 2'(d1); r.dly[2] = 2'(d2); r.dly[3] = 2'(d3);
      for (int i = 0; i < 4; i++) r.exp[i] = mdl(acc_t'(r.val[i]));
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
      if (rand_ready) s_if.out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   task automatic drive(input logic [3:0] mask, input int v0, input int v1,
                        input int v2, input int v3);
      acc_in_0 = acc_t'(v0);
      acc_in_1 = acc_t'(v1);
      acc_in_2 = acc_t'(v2);
      acc_in_3 = acc_t'(v3);
      valid_in = mask;
      step();
      valid_in = '0;
   endtask

   task automatic push4(input int v0, input int v1, input int v2, input int v3);
      exp_q.push_back(beat(0, acc_t'(v0)));
      exp_q.push_back(beat(1, acc_t'(v1)));
      exp_q.push_back(beat(2, acc_t'(v2)));
      exp_q.push_back(beat(3, acc_t'(v3)));
   endtask

   task automatic wait_idle(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         if (!busy && exp_q.size() == 0) done = 1'b1;
         else step();
      end
      check({name, "_idle_busy"}, longint'(busy), 0);
      check({name, "_idle_queue"}, longint'(exp_q.size()), 0);
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (!rst && s_if.out_valid && s_if.out_ready) begin
         logic [EW-1:0] got;
         logic [EW-1:0] req;
         got = {s_if.out_last, s_if.out_lane, s_if.out_data};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat_unexpected: actual %h required no beat", got);
         end else begin
            req = exp_q.pop_front();
            if (got !== req) begin
               n_fail++;
               $display("FAIL beat: actual last/lane/data %h required %h", got, req);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   vec_t vecs [7];

   initial begin
      vecs[0] = mk(10, -3, 7, 100,          0, 0, 0, 0);
      vecs[1] = mk(1, 2, 3, 4,              3, 2, 1, 0);
      vecs[2] = mk(32767, -32768, -1, 0,    1, 0, 3, 2);
      vecs[3] = mk(-8, 0, 16, -32768,       0, 1, 2, 3);
      vecs[4] = mk(555, -555, 1234, -4321,  2, 2, 0, 1);
      vecs[5] = mk(-100, 200, -300, 400,    0, 3, 0, 3);
      vecs[6] = mk(12, 34, 56, 78,          1, 1, 1, 1);

      rst = 1'b1; flush = 1'b0; valid_in = '0;
      acc_in_0 = '0; acc_in_1 = '0; acc_in_2 = '0; acc_in_3 = '0;
      s_if.out_ready = 1'b1;
      step(); step();

      // Reset values
      check("rst_out_valid", longint'(s_if.out_valid), 0);
      check("rst_out_data",  longint'(s_if.out_data), 0);
      check("rst_out_lane",  longint'(s_if.out_lane), 0);
      check("rst_out_last",  longint'(s_if.out_last), 0);
      check("rst_overrun",   longint'(overrun), 0);
      check("rst_busy",      longint'(busy), 0);
      rst = 1'b0;
      step();

      // Tile in order: latency and back-to-back beats
      push4(10, -3, 7, 100);
      drive(4'b1111, 10, -3, 7, 100);
      check("t1_latency_not_yet", longint'(s_if.out_valid), 0);
      check("t1_busy_captured", longint'(busy), 1);
      step();
      check("t1_b0_valid", longint'(s_if.out_valid), 1);
      check("t1_b0_data", longint'(s_if.out_data), longint'(mdl(10)));
      check("t1_b0_last", longint'(s_if.out_last), 0);
      step();
      check("t1_b1_data", longint'(s_if.out_data), longint'(mdl(-3)));
      check("t1_b1_lane", longint'(s_if.out_lane), 1);
      step();
      check("t1_b2_data", longint'(s_if.out_data), longint'(mdl(7)));
      step();
      check("t1_b3_data", longint'(s_if.out_data), longint'(mdl(100)));
      check("t1_b3_last", longint'(s_if.out_last), 1);
      step();
      check("t1_after_valid", longint'(s_if.out_valid), 0);
      check("t1_after_busy", longint'(busy), 0);

      // Out of order arrival: lane 2 first, nothing leaves before lane 0
      push4(9, 4, 5, 6);
      drive(4'b0100, 0, 0, 5, 0);
      for (int i = 0; i < 3; i++) begin
         check("t2_wait_lane0", longint'(s_if.out_valid), 0);
         step();
      end
      drive(4'b0001, 9, 0, 0, 0);
      drive(4'b0010, 0, 4, 0, 0);
      drive(4'b1000, 0, 0, 0, 6);
      wait_idle("t2");

      // Backpressure: full tile held behind out_ready=0
      s_if.out_ready = 1'b0;
      push4(-11, 22, -33, 44);
      drive(4'b1111, -11, 22, -33, 44);
      step();
      for (int i = 0; i < 5; i++) begin
         check("t3_hold_valid", longint'(s_if.out_valid), 1);
         check("t3_hold_data", longint'(s_if.out_data), longint'(mdl(-11)));
         check("t3_hold_lane", longint'(s_if.out_lane), 0);
         step();
      end
      s_if.out_ready = 1'b1;
      wait_idle("t3");

      // Overrun: lane 1 stuck behind empty lane 0, then hit again
      drive(4'b0010, 0, -1234, 0, 0);
      step();
      check("t4_stalled", longint'(s_if.out_valid), 0);
      check("t4_no_overrun_yet", longint'(overrun), 0);
      drive(4'b0010, 0, 55, 0, 0);
      check("t4_overrun_set", longint'(overrun), 1);
      step(); step();
      check("t4_overrun_sticky", longint'(overrun), 1);
      push4(11, -1234, 22, 33);
      drive(4'b1101, 11, 0, 22, 33);
      wait_idle("t4");
      check("t4_overrun_after_drain", longint'(overrun), 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("t4_overrun_flushed", longint'(overrun), 0);

      // Same-cycle drain and capture on lane 0: no overrun, both values emitted
      exp_q.push_back(beat(0, 1));
      exp_q.push_back(beat(1, 41));
      exp_q.push_back(beat(2, 42));
      exp_q.push_back(beat(3, 43));
      push4(2, 51, 52, 53);
      drive(4'b0001, 1, 0, 0, 0);
      drive(4'b0001, 2, 0, 0, 0);
      check("t7_no_overrun", longint'(overrun), 0);
      check("t7_first_beat", longint'(s_if.out_data), longint'(mdl(1)));
      drive(4'b1110, 0, 41, 42, 43);
      step(); step(); step(); step();
      drive(4'b1110, 0, 51, 52, 53);
      wait_idle("t7");
      check("t7_no_overrun_end", longint'(overrun), 0);

      // Flush then reset mid-tile, each followed by a fresh tile from lane 0
      for (int k = 0; k < 2; k++) begin
         s_if.out_ready = 1'b0;
         drive(4'b0011, 70, 71, 0, 0);
         drive(4'b0010, 0, 72, 0, 0);   // lane 1 full: sets overrun
         check("t5_pre_valid", longint'(s_if.out_valid), 1);
         check("t5_pre_overrun", longint'(overrun), 1);
         if (k == 0) flush = 1'b1; else rst = 1'b1;
         drive(4'b0100, 0, 0, 99, 0);   // dropped: clear wins
         flush = 1'b0; rst = 1'b0;
         check("t5_clr_valid", longint'(s_if.out_valid), 0);
         check("t5_clr_busy", longint'(busy), 0);
         check("t5_clr_overrun", longint'(overrun), 0);
         check("t5_clr_data", longint'(s_if.out_data), 0);
         step();
         check("t5_clr_busy_later", longint'(busy), 0);
         s_if.out_ready = 1'b1;
         push4(80 + k, 81, 82, 83);
         drive(4'b1111, 80 + k, 81, 82, 83);
         step();
         check("t5_restart_lane", longint'(s_if.out_lane), 0);
         wait_idle("t5");
      end

      // Table-driven tiles under random backpressure
      rand_ready = 1'b1;
      for (int t = 0; t < 7; t++) begin
         for (int l = 0; l < 4; l++) exp_q.push_back({l == 3, lane_t'(l), vecs[t].exp[l]});
         for (int c = 0; c < 4; c++) begin
            logic [3:0] mask;
            for (int l = 0; l < 4; l++) mask[l] = (vecs[t].dly[l] == 2'(c));
            acc_in_0 = acc_t'(vecs[t].val[0]);
            acc_in_1 = acc_t'(vecs[t].val[1]);
            acc_in_2 = acc_t'(vecs[t].val[2]);
            acc_in_3 = acc_t'(vecs[t].val[3]);
            valid_in = mask;
            step();
         end
         valid_in = '0;
         wait_idle("table");
         check("table_overrun", longint'(overrun), 0);
      end
      rand_ready = 1'b0;
      s_if.out_ready = 1'b1;
      step();

      check("final_queue_empty", longint'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
